ray_generator: RTL and testbench
================================

RAY_GENERATOR -- requirements
Module: ray_generator

Interface
REQ-001 Parameter IMG_W, default 640, image width in pixels (1..65535).
REQ-002 Parameter IMG_H, default 480, image height in pixels (1..65535).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  frame start request; sampled only in IDLE.
REQ-006 left_x, top_y, step_x, step_y, focal_z  in  32 each  Q16.16 frame setup: first-pixel x, first-row y, pixel pitch x/y, constant z; latched on accepted start.
REQ-007 busy  out  1  high from the cycle after an accepted start until return to IDLE.
REQ-008 done  out  1  one-cycle pulse when the last ray of the frame is accepted downstream.
REQ-009 norm_vx, norm_vy, norm_vz  out  32 each  Q16.16 unnormalized direction driven to the normalize stage.
REQ-010 norm_start  out  1  one-cycle request to the normalize stage.
REQ-011 norm_finish  in  1  normalize-stage completion level; goes low the edge after norm_start, high when result valid.
REQ-012 norm_rx, norm_ry, norm_rz  in  32 each  Q16.16 normalized result.
REQ-013 ray_valid  out  1 / ray_ready  in  1  downstream valid/ready handshake.
REQ-014 ray_px, ray_py  out  16 each  pixel coordinate of the presented ray.
REQ-015 ray_dx, ray_dy, ray_dz  out  32 each  Q16.16 normalized direction of the presented ray.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT, OUT.
REQ-017 IDLE + start=1 SHALL latch setup inputs, set cur_x=left_x, cur_y=top_y, px=py=0, go to ISSUE; start in any other state SHALL be ignored.
REQ-018 ISSUE SHALL assert norm_start for exactly one cycle, then go to WAIT.
REQ-019 norm_vx/vy/vz SHALL equal cur_x/cur_y/latched focal_z and SHALL stay constant from ISSUE until the WAIT->OUT transition.
REQ-020 WAIT SHALL ignore norm_finish in the cycle of the ISSUE edge (stale high) and, on the first sampled norm_finish=1, capture norm_r* into ray_d*, px/py into ray_px/py, and go to OUT.
REQ-021 OUT SHALL hold ray_valid=1 with all ray_* outputs stable until ray_ready=1; a ray transfers on the edge where valid and ready are both 1.
REQ-022 On transfer with px<IMG_W-1: px+=1, cur_x+=step_x, go to ISSUE.
REQ-023 On transfer with px=IMG_W-1 and py<IMG_H-1: px=0, cur_x=left_x, py+=1, cur_y-=step_y, go to ISSUE.
REQ-024 On transfer of pixel (IMG_W-1, IMG_H-1): pulse done for one cycle, go to IDLE.
REQ-025 cur_x/cur_y arithmetic SHALL be 32-bit two's complement, wrapping modulo 2^32 without saturation or flag.
REQ-026 Minimum per-ray period SHALL be 3 cycles plus normalize latency (ISSUE, WAIT cycles, OUT with ready=1).
REQ-027 ray_valid SHALL be 0 in every state other than OUT; norm_start SHALL be 0 outside ISSUE.

Reset
REQ-028 rst_n=0 at any time, including mid-frame, SHALL immediately force IDLE, busy=0, done=0, norm_start=0, ray_valid=0, and zero all counters, cur_x/cur_y, norm_v*, ray_p*, ray_d*.
REQ-029 After rst_n rises, the first start SHALL begin a fresh frame at pixel (0,0).

Structure
REQ-030 Shared package ray_pkg SHALL hold the Q16.16 width/fraction constants (WORD_W=32, FRAC_W=16) and the generator state encoding.
REQ-031 Pixel/row counting with wrap and last-pixel detect SHALL be one sub-module, ray_scan_counter; the FSM and accumulators stay in ray_generator.

Verification
REQ-032 IMG_W=2, IMG_H=2, left_x=0xFFFF0000, top_y=0x00010000, step 1.0, focal 1.0, normalize model latency 5, ready=1 -> rays (0,0),(1,0),(0,1),(1,1) with norm_v* (-1,1,1),(0,1,1),(-1,0,1),(0,0,1), done pulse once, busy low after.
REQ-033 ready held low 10 cycles in OUT -> ray_valid and ray_* stable, no new norm_start, transfer on first ready=1.
REQ-034 Second start during WAIT -> ignored; frame sequence and ray count unchanged.
REQ-035 rst_n pulsed low in WAIT of pixel (1,0) -> all outputs zero same cycle; next start yields (0,0) first.
REQ-036 IMG_W=IMG_H=1 -> exactly one norm_start, one ray (0,0), done 1 cycle after transfer.
REQ-037 norm_finish held high before start (stale) -> ray captured only after norm_finish low-then-high, value equals model result.

Source files
------------

// File: rtl/ray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ray_pkg
// Description : Shared Q16.16 widths and generator state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ray_pkg;

    localparam int WORD_W = 32;
    localparam int FRAC_W = 16;
    localparam int PIX_W  = 16;

    typedef logic [WORD_W-1:0] q16_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } gen_state_t;

endpackage
`default_nettype wire

// File: rtl/ray_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : ray_scan_counter
// Description : Raster pixel/row counter with row-end and frame-end detect.
// Revision    : 1.0 - initial release
// ============================================================================
module ray_scan_counter
    import ray_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [PIX_W-1:0] o_px,
    output logic [PIX_W-1:0] o_py,
    output logic             o_row_end,
    output logic             o_frame_end
);

    localparam logic [PIX_W-1:0] c_last_x = PIX_W'(IMG_W - 1);
    localparam logic [PIX_W-1:0] c_last_y = PIX_W'(IMG_H - 1);

    logic [PIX_W-1:0] r_px;
    logic [PIX_W-1:0] r_py;

    assign o_px        = r_px;
    assign o_py        = r_py;
    assign o_row_end   = (r_px == c_last_x);
    assign o_frame_end = o_row_end && (r_py == c_last_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px <= '0;
            r_py <= '0;
        end else if (i_clear) begin
            r_px <= '0;
            r_py <= '0;
        end else if (i_advance) begin
            if (!o_row_end) begin
                r_px <= r_px + 1'b1;
            end else begin
                r_px <= '0;
                r_py <= o_frame_end ? '0 : r_py + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ray_generator.sv
`default_nettype none
// ============================================================================
// Module      : ray_generator
// Description : Raster ray generator; issues each pixel direction to an
//               external normalize stage and presents the result downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module ray_generator
    import ray_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] left_x,
    input  logic [WORD_W-1:0] top_y,
    input  logic [WORD_W-1:0] step_x,
    input  logic [WORD_W-1:0] step_y,
    input  logic [WORD_W-1:0] focal_z,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] norm_vx,
    output logic [WORD_W-1:0] norm_vy,
    output logic [WORD_W-1:0] norm_vz,
    output logic              norm_start,
    input  logic              norm_finish,
    input  logic [WORD_W-1:0] norm_rx,
    input  logic [WORD_W-1:0] norm_ry,
    input  logic [WORD_W-1:0] norm_rz,
    output logic              ray_valid,
    input  logic              ray_ready,
    output logic [PIX_W-1:0]  ray_px,
    output logic [PIX_W-1:0]  ray_py,
    output logic [WORD_W-1:0] ray_dx,
    output logic [WORD_W-1:0] ray_dy,
    output logic [WORD_W-1:0] ray_dz
);

    gen_state_t       r_state;
    gen_state_t       w_state_nxt;
    q16_t             r_left_x;
    q16_t             r_step_x;
    q16_t             r_step_y;
    q16_t             r_focal_z;
    q16_t             r_cur_x;
    q16_t             r_cur_y;
    logic             r_wait_first;
    logic             r_done;
    logic             w_accept;
    logic             w_capture;
    logic             w_xfer;
    logic [PIX_W-1:0] w_px;
    logic [PIX_W-1:0] w_py;
    logic             w_row_end;
    logic             w_frame_end;

    // The first WAIT cycle may still see the previous request's finish level.
    assign w_accept  = (r_state == IDLE) && start;
    assign w_capture = (r_state == WAIT) && !r_wait_first && norm_finish;
    assign w_xfer    = (r_state == OUT) && ray_ready;

    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign norm_start = (r_state == ISSUE);
    assign ray_valid  = (r_state == OUT);
    assign norm_vx    = r_cur_x;
    assign norm_vy    = r_cur_y;
    assign norm_vz    = r_focal_z;

    ray_scan_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_accept),
        .i_advance   (w_xfer),
        .o_px        (w_px),
        .o_py        (w_py),
        .o_row_end   (w_row_end),
        .o_frame_end (w_frame_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_capture) w_state_nxt = OUT;
            OUT:     if (ray_ready) w_state_nxt = w_frame_end ? IDLE : ISSUE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left_x     <= '0;
            r_step_x     <= '0;
            r_step_y     <= '0;
            r_focal_z    <= '0;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_wait_first <= 1'b0;
            r_done       <= 1'b0;
            ray_px       <= '0;
            ray_py       <= '0;
            ray_dx       <= '0;
            ray_dy       <= '0;
            ray_dz       <= '0;
        end else begin
            r_wait_first <= (r_state == ISSUE);
            r_done       <= w_xfer && w_frame_end;
            if (w_accept) begin
                r_left_x  <= left_x;
                r_step_x  <= step_x;
                r_step_y  <= step_y;
                r_focal_z <= focal_z;
                r_cur_x   <= left_x;
                r_cur_y   <= top_y;
            end
            if (w_capture) begin
                ray_px <= w_px;
                ray_py <= w_py;
                ray_dx <= norm_rx;
                ray_dy <= norm_ry;
                ray_dz <= norm_rz;
            end
            // Rows descend in y: each new row subtracts the vertical pitch.
            if (w_xfer && !w_frame_end) begin
                if (!w_row_end) begin
                    r_cur_x <= r_cur_x + r_step_x;
                end else begin
                    r_cur_x <= r_left_x;
                    r_cur_y <= r_cur_y - r_step_y;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ray_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ray_generator
// Description : Self-checking bench: 2x2 generator against a raster model
//               with a stale-finish normalize model, plus a 1x1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ray_generator;

    localparam int c_w   = 2;
    localparam int c_h   = 2;
    localparam int c_n   = c_w * c_h;
    localparam int c_lat = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, ray_ready;
    logic [31:0] left_x, top_y, step_x, step_y, focal_z;
    logic        busy, done, norm_start, norm_finish, ray_valid;
    logic [31:0] norm_vx, norm_vy, norm_vz, norm_rx, norm_ry, norm_rz;
    logic [15:0] ray_px, ray_py;
    logic [31:0] ray_dx, ray_dy, ray_dz;

    logic        start1, ray_ready1;
    logic        busy1, done1, norm_start1, norm_finish1, ray_valid1;
    logic [31:0] norm_vx1, norm_vy1, norm_vz1, norm_rx1, norm_ry1, norm_rz1;
    logic [15:0] ray_px1, ray_py1;
    logic [31:0] ray_dx1, ray_dy1, ray_dz1;

    ray_generator #(.IMG_W(c_w), .IMG_H(c_h)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .left_x(left_x), .top_y(top_y), .step_x(step_x), .step_y(step_y), .focal_z(focal_z),
        .busy(busy), .done(done),
        .norm_vx(norm_vx), .norm_vy(norm_vy), .norm_vz(norm_vz), .norm_start(norm_start),
        .norm_finish(norm_finish), .norm_rx(norm_rx), .norm_ry(norm_ry), .norm_rz(norm_rz),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_px(ray_px), .ray_py(ray_py),
        .ray_dx(ray_dx), .ray_dy(ray_dy), .ray_dz(ray_dz)
    );

    ray_generator #(.IMG_W(1), .IMG_H(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .left_x(left_x), .top_y(top_y), .step_x(step_x), .step_y(step_y), .focal_z(focal_z),
        .busy(busy1), .done(done1),
        .norm_vx(norm_vx1), .norm_vy(norm_vy1), .norm_vz(norm_vz1), .norm_start(norm_start1),
        .norm_finish(norm_finish1), .norm_rx(norm_rx1), .norm_ry(norm_ry1), .norm_rz(norm_rz1),
        .ray_valid(ray_valid1), .ray_ready(ray_ready1), .ray_px(ray_px1), .ray_py(ray_py1),
        .ray_dx(ray_dx1), .ray_dy(ray_dy1), .ray_dz(ray_dz1)
    );

    // Normalize model: finish stays high (stale) one cycle after the request,
    // drops, and rises c_lat edges after the request with a salted result.
    int          n_cnt;
    logic        n_drop;
    logic [31:0] n_vx, n_vy, n_vz, n_salt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            norm_finish <= 1'b1;
            n_cnt       <= 0;
            n_drop      <= 1'b0;
            norm_rx     <= '0;
            norm_ry     <= '0;
            norm_rz     <= '0;
        end else if (norm_start) begin
            n_cnt  <= c_lat;
            n_drop <= 1'b1;
            n_vx   <= norm_vx;
            n_vy   <= norm_vy;
            n_vz   <= norm_vz;
            n_salt <= $urandom;
        end else begin
            if (n_drop) begin
                norm_finish <= 1'b0;
                n_drop      <= 1'b0;
            end
            if (n_cnt == 1) begin
                norm_finish <= 1'b1;
                norm_rx     <= n_vx + n_salt;
                norm_ry     <= n_vy ^ n_salt;
                norm_rz     <= n_vz - n_salt;
            end
            if (n_cnt != 0) n_cnt <= n_cnt - 1;
        end
    end

    int          n1_cnt;
    logic        n1_drop;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            norm_finish1 <= 1'b1;
            n1_cnt       <= 0;
            n1_drop      <= 1'b0;
            norm_rx1     <= '0;
            norm_ry1     <= '0;
            norm_rz1     <= '0;
        end else if (norm_start1) begin
            n1_cnt  <= 3;
            n1_drop <= 1'b1;
        end else begin
            if (n1_drop) begin
                norm_finish1 <= 1'b0;
                n1_drop      <= 1'b0;
            end
            if (n1_cnt == 1) begin
                norm_finish1 <= 1'b1;
                norm_rx1     <= norm_vx1 ^ 32'h5A5A_5A5A;
                norm_ry1     <= norm_vy1 + 32'h0000_1234;
                norm_rz1     <= ~norm_vz1;
            end
            if (n1_cnt != 0) n1_cnt <= n1_cnt - 1;
        end
    end

    int n_errs = 0, n_checks = 0;
    int cyc = 0;
    int n_issue = 0, n_done = 0, n_xfer = 0;
    int n1_issue = 0, n1_done = 0, n1_xfer = 0, done1_cyc = 0, xfer1_cyc = 0;
    logic start_next = 1'b0, start1_next = 1'b0, scramble = 1'b0, log_en = 1'b0;
    int ready_mode = 0;

    // Reference model state, expressed in rays of the raster rather than states.
    logic        m_active = 1'b0, m_issue_due = 1'b0, m_pend = 1'b0, m_first = 1'b0;
    logic        m_out = 1'b0, m_done_due = 1'b0;
    int          m_idx = 0;
    logic [31:0] ex_vx[c_n], ex_vy[c_n], ex_vz[c_n];
    int          ex_px[c_n], ex_py[c_n];
    logic [31:0] log_vx[c_n], log_vy[c_n], log_vz[c_n];
    int          log_cnt = 0;
    logic [31:0] lit_vx[c_n], lit_vy[c_n];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s: wait budget expired without the expected event (cycle %0d)", name, cyc);
    endtask

    task automatic build_frame();
        for (int k = 0; k < c_n; k++) begin
            ex_px[k] = k % c_w;
            ex_py[k] = k / c_w;
            ex_vx[k] = left_x + 32'(ex_px[k]) * step_x;
            ex_vy[k] = top_y - 32'(ex_py[k]) * step_y;
            ex_vz[k] = focal_z;
        end
    endtask

    task automatic compare();
        logic act_now;
        if (!rst_n) begin
            chk("reset_ctrl", 32'({busy, done, norm_start, ray_valid}), 32'd0);
            chk("reset_vec", norm_vx | norm_vy | norm_vz | ray_dx | ray_dy | ray_dz | {ray_px, ray_py}, 32'd0);
            m_active = 0; m_issue_due = 0; m_pend = 0; m_first = 0; m_out = 0; m_done_due = 0; m_idx = 0;
            return;
        end
        act_now = m_active;
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done_due));
        chk("norm_start", 32'(norm_start), 32'(m_issue_due));
        chk("ray_valid", 32'(ray_valid), 32'(m_out));
        if (norm_start) n_issue++;
        if (done) n_done++;
        if (ray_valid && ray_ready) n_xfer++;
        if (norm_start && m_issue_due) begin
            chk("norm_vx", norm_vx, ex_vx[m_idx]);
            chk("norm_vy", norm_vy, ex_vy[m_idx]);
            chk("norm_vz", norm_vz, ex_vz[m_idx]);
            if (log_en && log_cnt < c_n) begin
                log_vx[log_cnt] = norm_vx;
                log_vy[log_cnt] = norm_vy;
                log_vz[log_cnt] = norm_vz;
                log_cnt++;
            end
        end
        if (ray_valid && m_out) begin
            chk("ray_px", 32'(ray_px), 32'(ex_px[m_idx]));
            chk("ray_py", 32'(ray_py), 32'(ex_py[m_idx]));
            chk("ray_dx", ray_dx, ex_vx[m_idx] + n_salt);
            chk("ray_dy", ray_dy, ex_vy[m_idx] ^ n_salt);
            chk("ray_dz", ray_dz, ex_vz[m_idx] - n_salt);
        end
        m_done_due = 1'b0;
        if (m_issue_due) begin
            m_issue_due = 1'b0; m_pend = 1'b1; m_first = 1'b1;
        end else if (m_pend && !m_out) begin
            if (!m_first && norm_finish) m_out = 1'b1;
            m_first = 1'b0;
        end else if (m_out && ray_ready) begin
            m_out = 1'b0; m_pend = 1'b0; m_idx++;
            if (m_idx == c_n) begin
                m_active = 1'b0; m_done_due = 1'b1;
            end else begin
                m_issue_due = 1'b1;
            end
        end
        if (!act_now && start) begin
            build_frame();
            m_active = 1'b1; m_idx = 0; m_issue_due = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start = start_next;   start_next = 1'b0;
        start1 = start1_next; start1_next = 1'b0;
        case (ready_mode)
            0:       ray_ready = 1'b1;
            1:       ray_ready = ($urandom_range(0, 3) != 0);
            default: ray_ready = 1'b0;
        endcase
        if (scramble) begin
            left_x = $urandom; top_y = $urandom; step_x = $urandom;
            step_y = $urandom; focal_z = $urandom;
        end
        cyc++;
        @(negedge clk);
        compare();
        if (norm_start1) n1_issue++;
        if (done1) begin n1_done++; done1_cyc = cyc; end
        if (ray_valid1 && ray_ready1) begin
            n1_xfer++; xfer1_cyc = cyc;
            chk("d1_px", 32'(ray_px1), 32'd0);
            chk("d1_py", 32'(ray_py1), 32'd0);
            chk("d1_dx", ray_dx1, left_x ^ 32'h5A5A_5A5A);
            chk("d1_dz", ray_dz1, ~focal_z);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 400) begin tick(); k++; end
        if (busy) timeout(name);
    endtask

    int i0, d0, x0, k;

    initial begin
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; ray_ready = 1'b1; ray_ready1 = 1'b1;
        left_x = '0; top_y = '0; step_x = '0; step_y = '0; focal_z = '0;
        lit_vx = '{32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000};
        lit_vy = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000};
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Literal 2x2 frame, ready always high.
        left_x = 32'hFFFF_0000; top_y = 32'h0001_0000;
        step_x = 32'h0001_0000; step_y = 32'h0001_0000; focal_z = 32'h0001_0000;
        log_en = 1'b1; log_cnt = 0; i0 = n_issue; d0 = n_done; x0 = n_xfer;
        start_next = 1'b1; tick(); tick();
        wait_idle("frame1");
        log_en = 1'b0;
        for (int j = 0; j < c_n; j++) begin
            chk("lit_vx", log_vx[j], lit_vx[j]);
            chk("lit_vy", log_vy[j], lit_vy[j]);
            chk("lit_vz", log_vz[j], 32'h0001_0000);
        end
        chk("f1_rays", 32'(n_xfer - x0), 32'd4);
        chk("f1_issue", 32'(n_issue - i0), 32'd4);
        chk("f1_done", 32'(n_done - d0), 32'd1);
        tick();
        chk("f1_busy_after", 32'(busy), 32'd0);

        // Downstream stall in OUT.
        ready_mode = 2;
        start_next = 1'b1; tick();
        k = 0;
        while (!ray_valid && k < 60) begin tick(); k++; end
        if (!ray_valid) timeout("stall_wait");
        i0 = n_issue;
        repeat (10) tick();
        chk("stall_issue", 32'(n_issue - i0), 32'd0);
        chk("stall_valid", 32'(ray_valid), 32'd1);
        ready_mode = 0; x0 = n_xfer;
        tick();
        chk("stall_xfer", 32'(n_xfer - x0), 32'd1);
        wait_idle("stall_frame");

        // Extra start while the frame is in WAIT.
        i0 = n_issue; d0 = n_done; x0 = n_xfer;
        start_next = 1'b1; tick(); tick(); tick();
        start_next = 1'b1;
        tick();
        wait_idle("restart_frame");
        chk("restart_rays", 32'(n_xfer - x0), 32'd4);
        chk("restart_issue", 32'(n_issue - i0), 32'd4);
        chk("restart_done", 32'(n_done - d0), 32'd1);
        tick();

        // Asynchronous reset during WAIT of pixel (1,0).
        i0 = n_issue;
        start_next = 1'b1; tick();
        k = 0;
        while ((n_issue - i0) < 2 && k < 60) begin tick(); k++; end
        if ((n_issue - i0) < 2) timeout("reset_wait");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_norm_start", 32'(norm_start), 32'd0);
        chk("rst_valid", 32'(ray_valid), 32'd0);
        chk("rst_norm_v", norm_vx | norm_vy | norm_vz, 32'd0);
        chk("rst_ray", ray_dx | ray_dy | ray_dz | {ray_px, ray_py}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        start_next = 1'b1; tick();
        k = 0;
        while (!ray_valid && k < 60) begin tick(); k++; end
        if (!ray_valid) timeout("post_reset_ray");
        chk("post_reset_px", 32'(ray_px), 32'd0);
        chk("post_reset_py", 32'(ray_py), 32'd0);
        wait_idle("post_reset_frame");
        tick();

        // Randomized setups, random backpressure and stray starts.
        scramble = 1'b1; ready_mode = 1; d0 = n_done; x0 = n_xfer;
        for (int f = 0; f < 8; f++) begin
            start_next = 1'b1; tick(); tick();
            k = 0;
            while (busy && k < 400) begin
                if (m_active && m_idx < c_n - 1 && $urandom_range(0, 7) == 0) start_next = 1'b1;
                tick(); k++;
            end
            if (busy) timeout("rand_frame");
            if ($urandom_range(0, 1) == 1) tick();
        end
        chk("rand_frames", 32'(n_done - d0), 32'd8);
        chk("rand_rays", 32'(n_xfer - x0), 32'd32);
        scramble = 1'b0; ready_mode = 0;
        tick();

        // Single-pixel image on the 1x1 instance.
        left_x = 32'h1234_5678; top_y = 32'h8000_0000; focal_z = 32'h0002_8000;
        start1_next = 1'b1; tick();
        k = 0;
        while ((k < 3 || busy1) && k < 40) begin tick(); k++; end
        if (busy1) timeout("d1_frame");
        tick();
        chk("d1_issue", 32'(n1_issue), 32'd1);
        chk("d1_rays", 32'(n1_xfer), 32'd1);
        chk("d1_done", 32'(n1_done), 32'd1);
        chk("d1_done_lat", 32'(done1_cyc - xfer1_cyc), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
